// File: rtl/cpu_bus_regfile.sv
// General register bank sharing one registered data bus with a keeper.
// Sources are one-hot; multi-driver cycles are blocked and flagged sticky.
module cpu_bus_regfile #(
    parameter int               WIDTH     = 16,
    parameter int               NREGS     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NREGS-1:0]       rout_sel,
    input  logic                   din_sel,
    input  logic                   aluout_sel,
    input  logic [NREGS-1:0]       rin_sel,
    input  logic [WIDTH-1:0]       din,
    input  logic [WIDTH-1:0]       aluout,
    input  logic                   err_clr,
    output logic [WIDTH-1:0]       obus,
    output logic [NREGS*WIDTH-1:0] regs_flat,
    output logic                   bus_err,
    output logic                   bus_idle
);

    localparam int CNT_W = $clog2(NREGS + 3);

    logic [NREGS-1:0][WIDTH-1:0] regs_q, regs_d;
    logic [WIDTH-1:0]            obus_q, obus_d;
    logic                        err_q, err_d;
    logic                        idle_q, idle_d;
    logic [WIDTH-1:0]            src_val;
    logic [CNT_W-1:0]            n_drv;

    function automatic logic [CNT_W-1:0] count_drivers(input logic [NREGS+1:0] sel);
        logic [CNT_W-1:0] n;
        n = '0;
        for (int i = 0; i < NREGS + 2; i++) begin
            n = n + CNT_W'(sel[i]);
        end
        return n;
    endfunction

    // AND-OR mux: only meaningful when exactly one source is selected,
    // and unselected sources contribute nothing.
    always_comb begin
        src_val = '0;
        for (int i = 0; i < NREGS; i++) begin
            if (rout_sel[i]) src_val = src_val | regs_q[i];
        end
        if (din_sel)    src_val = src_val | din;
        if (aluout_sel) src_val = src_val | aluout;
    end

    assign n_drv = count_drivers({aluout_sel, din_sel, rout_sel});

    always_comb begin
        obus_d = obus_q;
        regs_d = regs_q;
        err_d  = err_q & ~err_clr;
        idle_d = (n_drv == '0);
        if (n_drv > CNT_W'(1)) begin
            // Conflict: keep bus, block all loads; set beats a same-cycle clear.
            err_d = 1'b1;
        end else begin
            if (n_drv == CNT_W'(1)) obus_d = src_val;
            for (int i = 0; i < NREGS; i++) begin
                if (rin_sel[i]) regs_d[i] = obus_d;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            regs_q <= {NREGS{RESET_VAL}};
            obus_q <= RESET_VAL;
            err_q  <= 1'b0;
            idle_q <= 1'b1;
        end else begin
            regs_q <= regs_d;
            obus_q <= obus_d;
            err_q  <= err_d;
            idle_q <= idle_d;
        end
    end

    assign obus      = obus_q;
    assign regs_flat = regs_q;
    assign bus_err   = err_q;
    assign bus_idle  = idle_q;

endmodule

// File: tb/tb_cpu_bus_regfile.sv
// Scoreboard bench driving a 16x8 and a 32x4 instance with identical stimulus.
module tb_cpu_bus_regfile;

    typedef struct packed {
        logic [31:0]  step;
        logic [31:0]  obus;
        logic [255:0] regs;
        logic         err;
        logic         idle;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  rout, rin;
    logic        din_sel, alu_sel, err_clr;
    logic [31:0] din, alu;

    logic [15:0]  obus_a;
    logic [127:0] regs_a;
    logic         err_a, idle_a;
    logic [31:0]  obus_b;
    logic [127:0] regs_b;
    logic         err_b, idle_b;

    int tests = 0;
    int fails = 0;
    int step_n = 0;

    exp_t qa[$];
    exp_t qb[$];

    logic [31:0] m_r [2][8];
    logic [31:0] m_obus [2];
    logic        m_err [2];
    logic        m_idle [2];

    always #5 clk = ~clk;

    cpu_bus_regfile #(.WIDTH(16), .NREGS(8), .RESET_VAL(16'h0)) dut_a (
        .clk(clk), .rst(rst), .rout_sel(rout), .din_sel(din_sel), .aluout_sel(alu_sel),
        .rin_sel(rin), .din(din[15:0]), .aluout(alu[15:0]), .err_clr(err_clr),
        .obus(obus_a), .regs_flat(regs_a), .bus_err(err_a), .bus_idle(idle_a)
    );

    cpu_bus_regfile #(.WIDTH(32), .NREGS(4), .RESET_VAL(32'h0)) dut_b (
        .clk(clk), .rst(rst), .rout_sel(rout[3:0]), .din_sel(din_sel), .aluout_sel(alu_sel),
        .rin_sel(rin[3:0]), .din(din), .aluout(alu), .err_clr(err_clr),
        .obus(obus_b), .regs_flat(regs_b), .bus_err(err_b), .bus_idle(idle_b)
    );

    function automatic void check(input string nm, input int step,
                                  input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s step %0d: got %h expected %h", nm, step, act, exp);
        end
    endfunction

    // Reference model: bus transfer rules applied to plain arrays.
    task automatic model_step(input int c);
        int          nr;
        int          drivers;
        logic [31:0] msk;
        logic [31:0] val;
        nr      = (c == 0) ? 8 : 4;
        msk     = (c == 0) ? 32'h0000_FFFF : 32'hFFFF_FFFF;
        drivers = 0;
        val     = 32'h0;
        if (rst) begin
            for (int i = 0; i < 8; i++) m_r[c][i] = 32'h0;
            m_obus[c] = 32'h0;
            m_err[c]  = 1'b0;
            m_idle[c] = 1'b1;
            return;
        end
        for (int i = 0; i < nr; i++) begin
            if (rout[i]) begin drivers++; val = m_r[c][i]; end
        end
        if (din_sel) begin drivers++; val = din & msk; end
        if (alu_sel) begin drivers++; val = alu & msk; end
        if (drivers >= 2) begin
            m_err[c]  = 1'b1;
            m_idle[c] = 1'b0;
        end else begin
            if (drivers == 1) m_obus[c] = val;
            m_idle[c] = (drivers == 0);
            for (int i = 0; i < nr; i++) begin
                if (rin[i]) m_r[c][i] = m_obus[c];
            end
            if (err_clr) m_err[c] = 1'b0;
        end
    endtask

    function automatic exp_t snapshot(input int c);
        exp_t e;
        e.step = step_n;
        e.obus = m_obus[c];
        for (int i = 0; i < 8; i++) e.regs[i*32 +: 32] = m_r[c][i];
        e.err  = m_err[c];
        e.idle = m_idle[c];
        return e;
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
        step_n++;
        model_step(0);
        model_step(1);
        qa.push_back(snapshot(0));
        qb.push_back(snapshot(1));
    endtask

    task automatic clear_inputs();
        rst = 1'b0; rout = 8'h0; rin = 8'h0;
        din_sel = 1'b0; alu_sel = 1'b0; err_clr = 1'b0;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (qa.size() > 0) begin
            e = qa.pop_front();
            check("A.obus", e.step, {16'h0, obus_a}, e.obus);
            for (int i = 0; i < 8; i++)
                check($sformatf("A.r%0d", i), e.step, {16'h0, regs_a[i*16 +: 16]}, e.regs[i*32 +: 32]);
            check("A.bus_err", e.step, {31'h0, err_a}, {31'h0, e.err});
            check("A.bus_idle", e.step, {31'h0, idle_a}, {31'h0, e.idle});
        end
        if (qb.size() > 0) begin
            e = qb.pop_front();
            check("B.obus", e.step, obus_b, e.obus);
            for (int i = 0; i < 4; i++)
                check($sformatf("B.r%0d", i), e.step, regs_b[i*32 +: 32], e.regs[i*32 +: 32]);
            check("B.bus_err", e.step, {31'h0, err_b}, {31'h0, e.err});
            check("B.bus_idle", e.step, {31'h0, idle_b}, {31'h0, e.idle});
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        clear_inputs();
        din = 32'h0; alu = 32'h0;
        rst = 1'b1;
        repeat (2) cyc();
        rst = 1'b0;
        cyc();

        // Load r2 via din, then broadcast r2 to r0/r7, then ALU into r2
        din = 32'h5A5A_A5A5; din_sel = 1'b1; rin = 8'b0000_0100;
        cyc(); clear_inputs();
        rout = 8'b0000_0100; rin = 8'b1000_0001;
        cyc(); clear_inputs();
        alu = 32'h8765_1234; alu_sel = 1'b1; rin = 8'b0000_0100;
        cyc(); clear_inputs();

        // Conflict, sticky hold, clear, and clear colliding with a new conflict
        rout = 8'b0000_0001; alu_sel = 1'b1; alu = 32'hFFFF_FFFF; rin = 8'b0000_1000;
        cyc(); clear_inputs();
        repeat (5) cyc();
        err_clr = 1'b1;
        cyc(); clear_inputs();
        rout = 8'b0000_0001; din_sel = 1'b1; err_clr = 1'b1;
        cyc(); clear_inputs();
        err_clr = 1'b1;
        cyc(); clear_inputs();

        // Keeper: bus holds and feeds r5 (r1 for the 4-register instance)
        alu = 32'h0000_1234; alu_sel = 1'b1;
        cyc(); clear_inputs();
        rin = 8'b0010_0010;
        cyc(); clear_inputs();

        // Self-move leaves the register unchanged
        rout = 8'b0000_0010; rin = 8'b0000_0010;
        cyc(); clear_inputs();

        // Reset wins over a pending load
        din = 32'hDEAD_BEEF; din_sel = 1'b1; rin = 8'b0000_0010; rst = 1'b1;
        cyc(); clear_inputs();
        cyc();

        for (int n = 0; n < 400; n++) begin
            int mode;
            int src;
            clear_inputs();
            din  = $urandom();
            alu  = $urandom();
            mode = $urandom_range(0, 9);
            if (mode <= 5) begin
                src = $urandom_range(0, 9);
                if (src < 8)       rout = 8'h01 << src;
                else if (src == 8) din_sel = 1'b1;
                else               alu_sel = 1'b1;
            end else if (mode >= 8) begin
                rout    = 8'($urandom());
                din_sel = 1'($urandom());
                alu_sel = 1'($urandom());
            end
            rin     = ($urandom_range(0, 3) == 0) ? 8'($urandom()) : (8'h01 << $urandom_range(0, 7));
            err_clr = ($urandom_range(0, 7) == 0);
            rst     = ($urandom_range(0, 59) == 0);
            cyc();
        end
        clear_inputs();

        repeat (2) @(negedge clk);
        #1;
        check("drain", step_n, 32'(qa.size() + qb.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/cpu_bus_regfile.md
Name: cpu_bus_regfile

Overview:
- Parametrised successor to the CPU output-bus multiplexer.
- Combines the NREGS x WIDTH general register bank with the shared data bus.
- Bus sources are one-hot: register outputs, external din, ALU result.
- Adds a registered bus with keeper (hold) behaviour, bus-to-register loading, and sticky detection of multi-driver conflicts.

Parameters:
- WIDTH, 16, data bus and register width in bits
- NREGS, 8, number of general registers (2..32)
- RESET_VAL, 0, value loaded into every register and obus on reset

Ports:
- clk  input  1  system clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- rout_sel  input  NREGS  one-hot register-to-bus drive select; bit i drives r[i]
- din_sel  input  1  drive din onto bus
- aluout_sel  input  1  drive aluout onto bus
- rin_sel  input  NREGS  register load enables from bus; bit i loads r[i]
- din  input  WIDTH  external data input
- aluout  input  WIDTH  ALU result
- err_clr  input  1  clears sticky bus_err
- obus  output  WIDTH  registered bus value
- regs_flat  output  NREGS*WIDTH  concatenated register contents, r[0] in LSBs
- bus_err  output  1  sticky flag: more than one bus driver was selected
- bus_idle  output  1  registered: no driver was selected last cycle

Behaviour:
- One clock, clk. Reset rst is synchronous and active-high.
- Reset: every r[i] = RESET_VAL, obus = RESET_VAL, bus_err = 0, bus_idle = 1. rst overrides all other inputs in the same cycle.
- Driver count: n_drv = popcount({rout_sel, din_sel, aluout_sel}), computed combinationally each cycle.
- bus_next when n_drv == 1: the value of the selected source. Register sources use current (pre-edge) r[i].
- n_drv == 1: on the edge, obus <= bus_next, and every r[i] with rin_sel[i] = 1 loads bus_next. A register-to-register move (rout_sel[a], rin_sel[b]) completes in one cycle. obus shows the moved value the cycle after the edge.
- n_drv == 0 (keeper): obus holds its previous value. Registers with rin_sel set load the held obus value. bus_idle <= 1. No error.
- n_drv >= 2 (conflict): obus holds its previous value, no register is written (rin_sel ignored), bus_err <= 1, bus_idle <= 0.
- bus_idle <= 0 whenever n_drv >= 1.
- bus_err is sticky until rst or err_clr. If err_clr and a new conflict occur in the same cycle, set wins (bus_err stays 1).
- rin_sel[i] and rout_sel[i] both set (self-move): r[i] reloads its own value, i.e. no change.
- Multiple rin_sel bits set: every selected register loads the same value (broadcast). This is legal.
- Latency: source to obus is 1 cycle. Source to destination register is 1 cycle. regs_flat reflects register state directly with no extra delay.
- No X propagation: unselected sources never affect obus.
- Arithmetic: none. Pure width-WIDTH transfers with no truncation or extension.
- Reset asserted mid-transfer: the pending load is discarded and reset values apply at that edge.

Test Plan:
- Reset, then idle: rst=1 for 2 cycles, then all selects 0 -> obus = 0, all regs 0, bus_idle = 1, bus_err = 0.
- Load via din: din = 16'hA5A5, din_sel = 1, rin_sel = 8'b0000_0100 for 1 cycle -> next cycle r2 = A5A5, obus = A5A5, bus_idle = 0.
- Move: rout_sel = 8'b0000_0100, rin_sel = 8'b1000_0001 -> next cycle r0 = r7 = A5A5 (broadcast). Then aluout = 16'h1234, aluout_sel = 1, rin_sel[2] = 1 -> r2 = 1234.
- Conflict: rout_sel[0] = 1 and aluout_sel = 1 with aluout = 16'hFFFF and rin_sel[3] = 1 -> obus holds its prior value, r3 unchanged, bus_err = 1. bus_err stays 1 across 5 idle cycles. err_clr = 1 clears it next cycle. err_clr asserted together with a new conflict -> bus_err stays 1.
- Keeper: obus = 1234, then all selects 0 with rin_sel[5] = 1 -> obus stays 1234, r5 = 1234, bus_idle = 1.
- Mid-operation reset: din_sel = 1, din = 16'hBEEF, rin_sel[1] = 1, rst = 1 in the same cycle -> r1 = 0, obus = 0. Re-run the directed scenarios with WIDTH = 32, NREGS = 4.
